game_input_ctrl: RTL

GAME_INPUT_CTRL -- requirements
Module: game_input_ctrl

---
 rtl/game_input_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/game_input_ctrl.sv
// Three-button game input front end: synchronize, debounce, and queue press events in a 4-deep FIFO.
// Define INPUT_AUTO_REPEAT_EN to enable auto-repeat on left/right while a button stays held.
module game_input_ctrl #(
  parameter int unsigned DEBOUNCE_CNT = 2,
  parameter int unsigned REPEAT_DELAY = 8,
  parameter int unsigned REPEAT_RATE  = 3
) (
  input  logic       buttonclk,
  input  logic       reset,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_throw,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [2:0] cmd_data,
  output logic [2:0] held,
  output logic       overflow
);

  typedef enum logic [1:0] {StIdle, StPressDb, StHeld, StRelDb} state_e;

  localparam logic [3:0] DbLimit = 4'(DEBOUNCE_CNT);

  logic [2:0] raw, sync1_q, sync2_q;
  state_e     state_q [3];
  state_e     state_d [3];
  logic [2:0] cnt_q [3];
  logic [2:0] cnt_d [3];
  logic [2:0] press_ev, ev_raw, ev;

  assign raw = {btn_throw, btn_right, btn_left};

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      state_d[i]  = state_q[i];
      cnt_d[i]    = cnt_q[i];
      press_ev[i] = 1'b0;
      held[i]     = (state_q[i] == StHeld) || (state_q[i] == StRelDb);
      unique case (state_q[i])
        StIdle: begin
          if (sync2_q[i]) begin
            // With a one-sample debounce the first high sample already completes the press.
            if (DbLimit <= 4'd1) begin
              state_d[i]  = StHeld;
              press_ev[i] = 1'b1;
              cnt_d[i]    = 3'd0;
            end else begin
              state_d[i] = StPressDb;
              cnt_d[i]   = 3'd1;
            end
          end
        end
        StPressDb: begin
          if (!sync2_q[i]) begin
            state_d[i] = StIdle;
            cnt_d[i]   = 3'd0;
          end else if (({1'b0, cnt_q[i]} + 4'd1) >= DbLimit) begin
            state_d[i]  = StHeld;
            press_ev[i] = 1'b1;
            cnt_d[i]    = 3'd0;
          end else begin
            cnt_d[i] = cnt_q[i] + 3'd1;
          end
        end
        StHeld: begin
          if (!sync2_q[i]) begin
            if (DbLimit <= 4'd1) begin
              state_d[i] = StIdle;
              cnt_d[i]   = 3'd0;
            end else begin
              state_d[i] = StRelDb;
              cnt_d[i]   = 3'd1;
            end
          end
        end
        StRelDb: begin
          if (sync2_q[i]) begin
            state_d[i] = StHeld;
            cnt_d[i]   = 3'd0;
          end else if (({1'b0, cnt_q[i]} + 4'd1) >= DbLimit) begin
            state_d[i] = StIdle;
            cnt_d[i]   = 3'd0;
          end else begin
            cnt_d[i] = cnt_q[i] + 3'd1;
          end
        end
        default: begin
          state_d[i] = StIdle;
          cnt_d[i]   = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge buttonclk) begin
    if (reset) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= StIdle;
        cnt_q[i]   <= 3'd0;
      end
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

`ifdef INPUT_AUTO_REPEAT_EN
  localparam logic [4:0] RptDelay = 5'(REPEAT_DELAY);
  localparam logic [4:0] RptRate  = 5'(REPEAT_RATE);

  // Timer reads k in the k-th cycle after the press; it only advances while staying in HELD.
  logic [4:0] rpt_cnt_q [2];
  logic [4:0] rpt_cnt_d [2];
  logic [1:0] rpt_first_q, rpt_first_d, rpt_ev;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rpt_cnt_d[i]   = rpt_cnt_q[i];
      rpt_first_d[i] = rpt_first_q[i];
      rpt_ev[i]      = 1'b0;
      if (press_ev[i]) begin
        rpt_cnt_d[i]   = 5'd1;
        rpt_first_d[i] = 1'b1;
      end else if (state_q[i] == StHeld && sync2_q[i]) begin
        if (rpt_cnt_q[i] == (rpt_first_q[i] ? RptDelay : RptRate)) begin
          rpt_ev[i]      = 1'b1;
          rpt_cnt_d[i]   = 5'd1;
          rpt_first_d[i] = 1'b0;
        end else begin
          rpt_cnt_d[i] = rpt_cnt_q[i] + 5'd1;
        end
      end
    end
  end

  always_ff @(posedge buttonclk) begin
    if (reset) begin
      rpt_first_q <= 2'b00;
      for (int i = 0; i < 2; i++) rpt_cnt_q[i] <= 5'd0;
    end else begin
      rpt_first_q <= rpt_first_d;
      for (int i = 0; i < 2; i++) rpt_cnt_q[i] <= rpt_cnt_d[i];
    end
  end

  assign ev_raw = {press_ev[2], press_ev[1:0] | rpt_ev};
`else
  logic unused_rpt_cfg;
  assign unused_rpt_cfg = ^{5'(REPEAT_DELAY), 5'(REPEAT_RATE)};
  assign ev_raw = press_ev;
`endif

  // Simultaneous left and right cancel each other.
  always_comb begin
    ev = ev_raw;
    if (ev_raw[0] && ev_raw[1]) ev[1:0] = 2'b00;
  end

  logic [2:0] fifo_q [4];
  logic [1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [2:0] count_q, count_d;
  logic       overflow_q, overflow_d;
  logic       push, pop, full, wr_en;

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    overflow_d = overflow_q;
    push       = |ev;
    pop        = cmd_valid & cmd_ready;
    full       = (count_q == 3'd4);
    wr_en      = push & (~full | pop);
    if (wr_en) wptr_d = wptr_q + 2'd1;
    if (pop) rptr_d = rptr_q + 2'd1;
    count_d = count_q + {2'b00, wr_en} - {2'b00, pop};
    if (push && full && !pop) overflow_d = 1'b1;
  end

  always_ff @(posedge buttonclk) begin
    if (reset) begin
      wptr_q     <= 2'd0;
      rptr_q     <= 2'd0;
      count_q    <= 3'd0;
      overflow_q <= 1'b0;
      for (int i = 0; i < 4; i++) fifo_q[i] <= 3'b000;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      if (wr_en) fifo_q[wptr_q] <= ev;
    end
  end

  assign cmd_valid = (count_q != 3'd0);
  assign cmd_data  = cmd_valid ? fifo_q[rptr_q] : 3'b000;
  assign overflow  = overflow_q;

endmodule
